// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle core: word RAM plus an MMIO page holding a TX byte FIFO
// and an optional compare timer (enabled by defining DMEM_MMIO_TIMER_EN).
module dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] OCC_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_COUNT  = 8'h08;
    localparam logic [7:0] OFF_CMP    = 8'h0C;

    logic              mmio_sel;
    logic [7:0]        offset;
    logic [RAM_AW-1:0] ram_index;
    logic              wr_txdata;
    logic              wr_status;
    logic              unused_addr_bits;

    assign mmio_sel         = (addr[31:16] == 16'hFFFF);
    assign offset           = addr[7:0];
    assign ram_index        = addr[RAM_AW+1:2];
    assign wr_txdata        = memwrite && mmio_sel && (offset == OFF_TXDATA);
    assign wr_status        = memwrite && mmio_sel && (offset == OFF_STATUS);
    assign unused_addr_bits = ^addr[15:8];

    // Word RAM: asynchronous read, no reset of contents.
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (!reset && memwrite && !mmio_sel) begin
            ram[ram_index] <= writedata;
        end
    end

    // TX FIFO
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   occ_reg;
    logic [FIFO_AW:0]   occ_next;
    logic               overflow_reg;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push;
    logic               overflow_set;

    assign empty        = (occ_reg == '0);
    assign full         = (occ_reg == OCC_FULL);
    assign tx_valid     = !empty;
    assign tx_data      = tx_valid ? fifo_mem[rd_ptr_reg] : 8'h00;
    assign pop          = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a store to a full FIFO still lands.
    assign push         = wr_txdata && (!full || pop);
    assign overflow_set = wr_txdata && full && !pop;

    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr_reg] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            occ_reg <= occ_next;
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (wr_status && writedata[3]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    logic [31:0] timer_count;
    logic [31:0] timer_cmp;
    logic        irq_pending;

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] count_reg;
    logic [31:0] cmp_reg;
    logic        irq_pending_reg;
    logic        wr_count;
    logic        wr_cmp;
    logic        match;

    assign wr_count = memwrite && mmio_sel && (offset == OFF_COUNT);
    assign wr_cmp   = memwrite && mmio_sel && (offset == OFF_CMP);
    assign match    = (cmp_reg != 32'd0) && (count_reg == cmp_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg       <= 32'd0;
            cmp_reg         <= 32'd0;
            irq_pending_reg <= 1'b0;
        end else begin
            count_reg <= wr_count ? writedata : count_reg + 32'd1;
            if (wr_cmp) begin
                cmp_reg <= writedata;
            end
            // A match outranks a simultaneous software clear.
            if (match) begin
                irq_pending_reg <= 1'b1;
            end else if (wr_status && writedata[2]) begin
                irq_pending_reg <= 1'b0;
            end
        end
    end

    assign timer_count = count_reg;
    assign timer_cmp   = cmp_reg;
    assign irq_pending = irq_pending_reg;
`else
    assign timer_count = 32'd0;
    assign timer_cmp   = 32'd0;
    assign irq_pending = 1'b0;
`endif

    assign irq = irq_pending;

    always_comb begin
        readdata = 32'd0;
        if (mmio_sel) begin
            case (offset)
                OFF_STATUS: readdata = {28'd0, overflow_reg, irq_pending, full, empty};
                OFF_COUNT:  readdata = timer_count;
                OFF_CMP:    readdata = timer_cmp;
                default:    readdata = 32'd0;
            endcase
        end else begin
            readdata = ram[ram_index];
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: expected TX bytes are queued as they are stored and
// compared as the stream delivers them; register reads are checked against constants.
module tb_dmem_mmio;
    localparam logic [31:0] A_TX     = 32'hFFFF0000;
    localparam logic [31:0] A_STATUS = 32'hFFFF0004;
    localparam logic [31:0] A_COUNT  = 32'hFFFF0008;
    localparam logic [31:0] A_CMP    = 32'hFFFF000C;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] exp_q [$];

    dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .addr(addr),
        .writedata(writedata),
        .readdata(readdata),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        $display("store addr=%h data=%h", a, d);
    endtask

    task automatic peek(input logic [31:0] a);
        addr = a;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; memwrite = 1'b0; tx_ready = 1'b0; addr = '0; writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", tx_valid);
        else pass_cnt++;
        total_cnt++;
        if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
        else pass_cnt++;
        peek(A_STATUS);
        total_cnt++;
        if (readdata !== 32'h1) $display("FAIL reset_status: got %h expected 00000001", readdata);
        else pass_cnt++;
        $display("reset done");
    endtask

    task automatic test_ram;
        store(32'h00000010, 32'hDEADBEEF);
        store(32'h000000FC, 32'h12345678);
        peek(32'h00000010);
        total_cnt++;
        if (readdata !== 32'hDEADBEEF) $display("FAIL ram_load: got %h expected deadbeef", readdata);
        else pass_cnt++;
        peek(32'h00000110);
        total_cnt++;
        if (readdata !== 32'hDEADBEEF) $display("FAIL ram_alias: got %h expected deadbeef", readdata);
        else pass_cnt++;
        peek(32'h000000FF);
        total_cnt++;
        if (readdata !== 32'h12345678) $display("FAIL ram_top_word: got %h expected 12345678", readdata);
        else pass_cnt++;
    endtask

    task automatic test_fifo_overflow;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            store(A_TX, 32'h41 + i);
            if (i < 8) exp_q.push_back(8'(8'h41 + i));
            if (i == 7) begin
                peek(A_STATUS);
                total_cnt++;
                if (readdata !== 32'h2) $display("FAIL status_full: got %h expected 00000002", readdata);
                else pass_cnt++;
            end
        end
        peek(A_STATUS);
        total_cnt++;
        if (readdata !== 32'hA) $display("FAIL status_overflow: got %h expected 0000000a", readdata);
        else pass_cnt++;
        store(A_STATUS, 32'h8);
        peek(A_STATUS);
        total_cnt++;
        if (readdata !== 32'h2) $display("FAIL overflow_w1c: got %h expected 00000002", readdata);
        else pass_cnt++;
    endtask

    task automatic test_drain;
        logic [7:0] exp;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            total_cnt++;
            if (tx_valid !== 1'b1 || tx_data !== exp)
                $display("FAIL drain_byte%0d: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, exp);
            else pass_cnt++;
            $display("pop data=%h", tx_data);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL drain_empty: got valid=%b expected 0", tx_valid);
        else pass_cnt++;
        peek(A_STATUS);
        total_cnt++;
        if (readdata !== 32'h1) $display("FAIL drain_status: got %h expected 00000001", readdata);
        else pass_cnt++;
    endtask

    task automatic test_full_push_pop;
        logic [7:0] exp;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            store(A_TX, 32'h10 + i);
            exp_q.push_back(8'(8'h10 + i));
        end
        addr = A_TX; writedata = 32'h5A; memwrite = 1'b1; tx_ready = 1'b1;
        exp_q.push_back(8'h5A);
        #1;
        exp = exp_q.pop_front();
        total_cnt++;
        if (tx_data !== exp) $display("FAIL full_pp_head: got %h expected %h", tx_data, exp);
        else pass_cnt++;
        @(posedge clk);
        #1;
        memwrite = 1'b0; tx_ready = 1'b0;
        $display("store addr=%h data=5a with pop", A_TX);
        peek(A_STATUS);
        total_cnt++;
        if (readdata !== 32'h2) $display("FAIL full_pp_status: got %h expected 00000002", readdata);
        else pass_cnt++;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            total_cnt++;
            if (tx_valid !== 1'b1 || tx_data !== exp)
                $display("FAIL full_pp_drain%0d: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, exp);
            else pass_cnt++;
            $display("pop data=%h", tx_data);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL full_pp_empty: got valid=%b expected 0", tx_valid);
        else pass_cnt++;
    endtask

    task automatic test_empty_push_pop;
        logic [7:0] exp;
        tx_ready = 1'b1;
        store(A_TX, 32'h77);
        exp_q.push_back(8'h77);
        exp = exp_q.pop_front();
        total_cnt++;
        if (tx_valid !== 1'b1 || tx_data !== exp)
            $display("FAIL empty_push: got valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, exp);
        else pass_cnt++;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL empty_push_popped: got valid=%b expected 0", tx_valid);
        else pass_cnt++;
    endtask

    task automatic test_other_offsets;
        store(32'hFFFF0010, 32'hFFFFFFFF);
        peek(32'hFFFF0010);
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL other_offset_read: got %h expected 00000000", readdata);
        else pass_cnt++;
        peek(A_TX);
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL txdata_read: got %h expected 00000000", readdata);
        else pass_cnt++;
        peek(32'h00000010);
        total_cnt++;
        if (readdata !== 32'hDEADBEEF) $display("FAIL mmio_not_ram: got %h expected deadbeef", readdata);
        else pass_cnt++;
    endtask

    task automatic test_timer;
`ifdef DMEM_MMIO_TIMER_EN
        store(A_CMP, 32'd20);
        store(A_COUNT, 32'd10);
        peek(A_COUNT);
        total_cnt++;
        if (readdata !== 32'd10) $display("FAIL timer_load: got %0d expected 10", readdata);
        else pass_cnt++;
        repeat (10) @(posedge clk);
        #1;
        peek(A_COUNT);
        total_cnt++;
        if (readdata !== 32'd20 || irq !== 1'b0)
            $display("FAIL timer_match_cycle: got count=%0d irq=%b expected count=20 irq=0", readdata, irq);
        else pass_cnt++;
        store(A_STATUS, 32'h4);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL timer_irq_set_wins: got %b expected 1", irq);
        else pass_cnt++;
        peek(A_STATUS);
        total_cnt++;
        if (readdata !== 32'h5) $display("FAIL timer_status: got %h expected 00000005", readdata);
        else pass_cnt++;
        store(A_STATUS, 32'h4);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL timer_irq_clear: got %b expected 0", irq);
        else pass_cnt++;
        store(A_COUNT, 32'hFFFFFFFF);
        peek(A_COUNT);
        total_cnt++;
        if (readdata !== 32'hFFFFFFFF) $display("FAIL timer_load_max: got %h expected ffffffff", readdata);
        else pass_cnt++;
        @(posedge clk);
        #1;
        peek(A_COUNT);
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL timer_wrap: got %h expected 00000000", readdata);
        else pass_cnt++;
        peek(A_CMP);
        total_cnt++;
        if (readdata !== 32'd20) $display("FAIL timer_cmp_read: got %0d expected 20", readdata);
        else pass_cnt++;
`else
        store(A_CMP, 32'd5);
        store(A_COUNT, 32'd123);
        peek(A_COUNT);
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL notimer_count: got %h expected 00000000", readdata);
        else pass_cnt++;
        peek(A_CMP);
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL notimer_cmp: got %h expected 00000000", readdata);
        else pass_cnt++;
        repeat (8) @(posedge clk);
        #1;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL notimer_irq: got %b expected 0", irq);
        else pass_cnt++;
        store(A_STATUS, 32'h4);
        peek(A_STATUS);
        total_cnt++;
        if (readdata !== 32'h1) $display("FAIL notimer_status: got %h expected 00000001", readdata);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) store(A_TX, 32'hC0 + i);
`ifdef DMEM_MMIO_TIMER_EN
        store(A_CMP, 32'd6);
        store(A_COUNT, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL reset_mid_pre_irq: got %b expected 1", irq);
        else pass_cnt++;
`endif
        peek(A_STATUS);
        total_cnt++;
        if (readdata[0] !== 1'b0) $display("FAIL reset_mid_pre_fill: got status %h expected not empty", readdata);
        else pass_cnt++;
        reset = 1'b1; memwrite = 1'b1; addr = A_TX; writedata = 32'h99;
        @(posedge clk);
        #1;
        reset = 1'b0; memwrite = 1'b0;
        $display("reset with concurrent store data=99");
        total_cnt++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00)
            $display("FAIL reset_mid_fifo: got valid=%b data=%h expected valid=0 data=00", tx_valid, tx_data);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_mid_irq: got %b expected 0", irq);
        else pass_cnt++;
        peek(A_STATUS);
        total_cnt++;
        if (readdata !== 32'h1) $display("FAIL reset_mid_status: got %h expected 00000001", readdata);
        else pass_cnt++;
        peek(A_COUNT);
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL reset_mid_count: got %h expected 00000000", readdata);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL reset_mid_store_dropped: got valid=%b expected 0", tx_valid);
        else pass_cnt++;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_fifo_overflow();
        test_drain();
        test_full_push_pop();
        test_empty_push_pop();
        test_other_offsets();
        test_timer();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d checks", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end
endmodule
